// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// FSM encoding, funct3 opcodes and the per-operation step count.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam int ITER_CNT = 32;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath: one shift-add (multiply) or restoring shift-subtract
// (divide) step per enabled cycle on a 64-bit accumulator.
module muldiv_iter_core (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        div_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] acc_next_o
);

    logic [63:0] acc_q;
    logic [31:0] b_q;
    logic [32:0] sum;
    logic [32:0] diff;

    // Divide keeps {remainder, dividend/quotient}; multiply keeps
    // {partial product, multiplier} and retires one multiplier bit per step.
    always_comb begin
        sum  = {1'b0, acc_q[63:32]} + {1'b0, b_q};
        diff = acc_q[63:31] - {1'b0, b_q};
        if (div_i) begin
            if (diff[32])
                acc_next_o = {acc_q[62:0], 1'b0};
            else
                acc_next_o = {diff[31:0], acc_q[30:0], 1'b1};
        end else if (acc_q[0]) begin
            acc_next_o = {sum, acc_q[31:1]};
        end else begin
            acc_next_o = {1'b0, acc_q[63:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            b_q   <= '0;
        end else if (load_i) begin
            acc_q <= {32'd0, a_i};
            b_q   <= b_i;
        end else if (step_i) begin
            acc_q <= acc_next_o;
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// RV32M multiply/divide controller: stalls the pipeline while the iterative
// core runs 32 steps, handles divide fast paths and applies sign fix-up.
module muldiv_controller
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_label_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [4:0]  rd_label_o
);

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic        neg_q;

    logic        a_sgn, b_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        is_div, is_rem, div_zero, div_ovf, fast, accept;
    logic [31:0] fast_res;
    logic [63:0] acc_next, prod;
    logic [31:0] iter_res;

    always_comb begin
        a_sgn    = funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        b_sgn    = funct3_i inside {F3_MULH, F3_DIV, F3_REM};
        a_neg    = a_sgn & rs1_i[31];
        b_neg    = b_sgn & rs2_i[31];
        a_mag    = a_neg ? neg32(rs1_i) : rs1_i;
        b_mag    = b_neg ? neg32(rs2_i) : rs2_i;
        is_div   = funct3_i[2];
        is_rem   = funct3_i[2] & funct3_i[1];
        div_zero = is_div & (rs2_i == 32'd0);
        div_ovf  = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
                   rs1_i == 32'h8000_0000 && rs2_i == 32'hFFFF_FFFF;
        fast     = div_zero | div_ovf;
        if (div_zero)
            fast_res = is_rem ? rs1_i : 32'hFFFF_FFFF;
        else
            fast_res = is_rem ? 32'd0 : 32'h8000_0000;
        accept   = ~rst_i & (state == IDLE) & start_i & ~flush_i;
        stall_o  = ~rst_i & (accept | (state == BUSY));
    end

    // Result is taken from the core's next value so it is ready on the
    // same edge that completes the final step.
    always_comb begin
        prod = neg_q ? neg64(acc_next) : acc_next;
        if (!op_q[2])
            iter_res = (op_q == F3_MUL) ? prod[31:0] : prod[63:32];
        else if (op_q[1])
            iter_res = neg_q ? neg32(acc_next[63:32]) : acc_next[63:32];
        else
            iter_res = neg_q ? neg32(acc_next[31:0]) : acc_next[31:0];
    end

    muldiv_iter_core u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept & ~fast),
        .step_i     ((state == BUSY) & ~flush_i),
        .div_i      (op_q[2]),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .acc_next_o (acc_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            rd_label_o <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= funct3_i;
                        rd_q  <= rd_label_i;
                        neg_q <= is_rem ? a_neg : (a_neg ^ b_neg);
                        cnt   <= '0;
                        if (fast) begin
                            state      <= DONE;
                            done_o     <= 1'b1;
                            result_o   <= fast_res;
                            rd_label_o <= rd_label_i;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(ITER_CNT - 1)) begin
                            state      <= DONE;
                            done_o     <= 1'b1;
                            result_o   <= iter_res;
                            rd_label_o <= rd_q;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed-vector bench for muldiv_controller with hand-computed results.
module tb_muldiv_controller;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2;
    logic [4:0]  rd_lab;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_label_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_controller dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .funct3_i   (f3),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rd_label_i (rd_lab),
        .flush_i    (flush),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_label_o (rd_label_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the block idle; returns one negedge after done.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int cyc;
        int stalls;
        logic [31:0] held;
        rst = 1'b0; flush = 1'b0; start = 1'b1;
        f3 = op; rs1 = a; rs2 = b; rd_lab = rd;
        #1 stalls = stall_o ? 1 : 0;
        @(negedge clk);
        start = 1'b0; f3 = ~op; rs1 = 32'hDEAD_BEEF; rs2 = 32'd0; rd_lab = ~rd;
        cyc = 1;
        while (!done_o && cyc < 40) begin
            if (stall_o) stalls++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(lat));
        chk({tag, "/result"}, result_o, exp);
        chk({tag, "/rd"}, {27'd0, rd_label_o}, {27'd0, rd});
        chk({tag, "/stall_in_done"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "/stall_cycles"}, 32'(stalls), (lat == 1) ? 32'd1 : 32'd33);
        held = result_o;
        @(negedge clk);
        chk({tag, "/done_one_cycle"}, {31'd0, done_o}, 32'd0);
        chk({tag, "/result_hold"}, result_o, held);
    endtask

    initial begin
        int seen_done;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        f3 = '0; rs1 = '0; rs2 = '0; rd_lab = '0;
        repeat (3) @(negedge clk);
        chk("reset/stall", {31'd0, stall_o}, 32'd0);
        chk("reset/done", {31'd0, done_o}, 32'd0);
        chk("reset/result", result_o, 32'd0);
        chk("reset/rd", {27'd0, rd_label_o}, 32'd0);

        run_op("mul_7xm3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33);
        run_op("mulhu_max", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 33);
        run_op("mulh_m1", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 33);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
        run_op("mulh_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 33);
        run_op("divu_by0", F3_DIVU, 32'd100, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
        run_op("rem_by0", F3_REM, 32'd5, 32'd0, 5'd9, 32'd5, 1);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, 33);
        run_op("remu_7_2", F3_REMU, 32'd7, 32'd2, 5'd14, 32'd1, 33);

        // flush wins over start while idle
        start = 1'b1; flush = 1'b1; f3 = F3_MUL; rs1 = 32'd2; rs2 = 32'd2; rd_lab = 5'd1;
        #1 chk("idle_flush/stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("idle_flush/no_busy", {31'd0, stall_o}, 32'd0);
        chk("idle_flush/no_done", {31'd0, done_o}, 32'd0);
        @(negedge clk);

        // flush at counter 10, then an immediate new start
        start = 1'b1; f3 = F3_DIVU; rs1 = 32'd1000; rs2 = 32'd3; rd_lab = 5'd20;
        @(negedge clk);
        start = 1'b0;
        seen_done = 0;
        for (int k = 1; k < 11; k++) begin
            if (done_o) seen_done = 1;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush/done_low", {31'd0, done_o}, 32'd0);
        chk("flush/stall_low", {31'd0, stall_o}, 32'd0);
        chk("flush/no_early_done", 32'(seen_done), 32'd0);
        run_op("divu_after_flush", F3_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 33);

        // reset at counter 20 with start held, then accept right after release
        start = 1'b1; f3 = F3_MUL; rs1 = 32'd5; rs2 = 32'd6; rd_lab = 5'd22;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 21; k++) @(negedge clk);
        rst = 1'b1; start = 1'b1; f3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd4; rd_lab = 5'd23;
        #1 chk("rst/stall_override", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        chk("rst/stall", {31'd0, stall_o}, 32'd0);
        chk("rst/done", {31'd0, done_o}, 32'd0);
        chk("rst/result", result_o, 32'd0);
        chk("rst/rd", {27'd0, rd_label_o}, 32'd0);
        run_op("mul_after_rst", F3_MUL, 32'd3, 32'd4, 5'd23, 32'd12, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
